pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- rs1_d  input  5  decode-stage source register 1.
- rs2_d  input  5  decode-stage source register 2.
- rd_e  input  5  execute-stage destination register.
- mem_read_e  input  1  execute-stage instruction is a load.
- branch_taken_e  input  1  execute-stage branch/jump resolved taken.
- mc_start_e  input  1  multi-cycle op (mul/div) entering EX this cycle.
- mc_cycles  input  4  total EX occupancy of that op, in cycles.
- ext_stall  input  1  memory not ready; freeze whole pipe.
- stall_f  output  1  hold PC and the IF/ID register.
- stall_d  output  1  hold the ID/EX register.
- stall_e  output  1  hold the EX/MEM register.
- flush_d  output  1  clear IF/ID to NOP 0x00000013.
- flush_e  output  1  clear ID/EX to NOP.
- flush_m  output  1  clear EX/MEM to NOP.
- busy  output  1  multi-cycle sequence in progress.
- stall_count  output  32  count of cycles with stall_f=1.
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL implement two states: IDLE and MC, plus a 4-bit remaining-cycle counter rem.
REQ-004 SHALL drive all stall and flush outputs combinationally from the current state and inputs, in this priority order: reset, ext_stall, MC, mc_start, branch, load-use.
REQ-005 ext_stall=1 (not in reset): stall_f=stall_d=stall_e=1, all flushes 0; state, rem and stall_count hold, except that stall_count increments.
REQ-006 In MC: stall_f=stall_d=stall_e=1, flush_m=1, flush_d=flush_e=0; branch_taken_e and load-use are ignored.
REQ-007 MC transitions: rem<=rem-1 each cycle; when rem==1 at the clock edge, go to IDLE.
REQ-008 In IDLE with mc_start_e=1 and mc_cycles>=2: same outputs as REQ-006 this cycle.
- If mc_cycles==2: stay in IDLE.
- Otherwise: go to MC with rem<=mc_cycles-2.
- Total stall cycles SHALL equal mc_cycles-1.
REQ-009 mc_start_e with mc_cycles of 0 or 1 SHALL be treated as a single-cycle op: no stall, no state change.
REQ-010 In IDLE with branch_taken_e=1 (not stalled per REQ-005/008): flush_d=flush_e=1, all stalls 0; load-use is suppressed.
REQ-011 Load-use hazard is mem_read_e=1, rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d). In IDLE with no higher-priority event, it gives stall_f=stall_d=1 and flush_e=1 for exactly that cycle; everything else 0.
REQ-012 With no event: all stalls and flushes 0.
REQ-013 busy SHALL equal (state==MC).
REQ-014 stall_count SHALL increment by 1 on each posedge with stall_f=1 and reset=0, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-015 With reset=1 at posedge: state<=IDLE, rem<=0, stall_count<=0.
REQ-016 While reset=1: flush_d=flush_e=flush_m=1 and stall_f=stall_d=stall_e=0, regardless of other inputs, so all pipeline registers load NOP.
REQ-017 Reset asserted mid-MC SHALL abort the sequence. On the first cycle after reset deasserts: IDLE, busy=0, all stalls 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset 2 cycles, then idle inputs -> flushes 1 during reset, then all outputs 0, stall_count=0.
- mem_read_e=1, rd_e=5, rs2_d=5 for one cycle -> stall_f=stall_d=flush_e=1 that cycle only; stall_count=1. Repeat with rd_e=0 -> no stall.
- Same load-use plus branch_taken_e=1 -> flush_d=flush_e=1, stalls 0.
- mc_start_e=1, mc_cycles=4 -> stalls and flush_m high for exactly 3 cycles, busy high 2 cycles; with mc_cycles=2 -> 1 stall cycle, busy never high; with mc_cycles=1 -> none.
- mc_cycles=5 with ext_stall=1 for 2 cycles mid-MC -> total stall cycles 6, rem frozen, flush_m=0 during ext_stall.
- Reset during MC, then stall_count preload near wrap by running 0xFFFFFFFF stall cycles (or force) -> abort per REQ-017; counter wraps to 0.

Source files
------------

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: generates stall/flush controls for a 5-stage pipe,
// sequences multi-cycle EX ops (mul/div), and counts front-end stall cycles.
module pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic        branch_taken_e,
  input  logic        mc_start_e,
  input  logic [3:0]  mc_cycles,
  input  logic        ext_stall,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        busy,
  output logic [31:0] stall_count
);

  typedef enum logic {IDLE, MC} state_t;

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       load_use;
  logic       mc_go;

  assign load_use = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  // Ops of 0 or 1 cycles finish in a single EX slot and need no sequencing.
  assign mc_go    = mc_start_e && (mc_cycles >= 4'd2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= 4'd0;
      stall_count <= 32'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (stall_f) stall_count <= stall_count + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (!ext_stall) begin
      if (state == MC) begin
        rem_nxt = rem - 4'd1;
        if (rem == 4'd1) state_nxt = IDLE;
      end else if (mc_go && (mc_cycles != 4'd2)) begin
        // The start cycle is itself a stall cycle, hence the -2.
        state_nxt = MC;
        rem_nxt   = mc_cycles - 4'd2;
      end
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (ext_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if ((state == MC) || mc_go) begin
      // EX is occupied: freeze everything upstream and bubble into MEM.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign busy = (state == MC);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed, table-driven bench for pipeline_controller: one table row per clock
// cycle, outputs compared mid-cycle against hand-computed expectations.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rd_e;
  logic        mem_read_e, branch_taken_e, mc_start_e, ext_stall;
  logic [3:0]  mc_cycles;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_controller dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_e           (rd_e),
    .mem_read_e     (mem_read_e),
    .branch_taken_e (branch_taken_e),
    .mc_start_e     (mc_start_e),
    .mc_cycles      (mc_cycles),
    .ext_stall      (ext_stall),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .busy           (busy),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  localparam logic [5:0] C_NONE  = 6'b000_000;
  localparam logic [5:0] C_RST   = 6'b000_111;
  localparam logic [5:0] C_EXT   = 6'b111_000;
  localparam logic [5:0] C_MC    = 6'b111_001;
  localparam logic [5:0] C_BR    = 6'b000_110;
  localparam logic [5:0] C_LU    = 6'b110_010;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, br, mcs;
    logic [3:0]  mcc;
    logic        ext;
    logic [5:0]  exp_ctl;
    logic        chk_state;
    logic        exp_busy;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic mr, input logic br,
                     input logic mcs, input logic [3:0] mcc, input logic ext,
                     input logic [5:0] exp_ctl, input logic chk_state,
                     input logic exp_busy, input logic [31:0] exp_cnt);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.br = br;
    v.mcs = mcs; v.mcc = mcc; v.ext = ext; v.exp_ctl = exp_ctl;
    v.chk_state = chk_state; v.exp_busy = exp_busy; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare 1 ns later.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; rs1_d = v.rs1; rs2_d = v.rs2; rd_e = v.rd;
    mem_read_e = v.mr; branch_taken_e = v.br; mc_start_e = v.mcs;
    mc_cycles = v.mcc; ext_stall = v.ext;
    #1;
    check({tag, " ctl"}, {26'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m},
          {26'd0, v.exp_ctl});
    if (v.chk_state) begin
      check({tag, " busy"}, {31'd0, busy}, {31'd0, v.exp_busy});
      check({tag, " stall_count"}, stall_count, v.exp_cnt);
    end
  endtask

  initial begin
    vec_t w;
    reset = 1'b1; rs1_d = '0; rs2_d = '0; rd_e = '0; mem_read_e = 1'b0;
    branch_taken_e = 1'b0; mc_start_e = 1'b0; mc_cycles = '0; ext_stall = 1'b0;

    //   rst rs1 rs2 rd  mr br mcs mcc ext  ctl     chk busy cnt
    // Reset for two cycles; registered state unknown before the first edge.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);
    // Load-use on rs2, then rd=0 (no hazard), then on rs1, then a mismatch.
    add(0, 1, 5, 5, 1, 0, 0, 0, 0, C_LU,   1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, C_NONE, 1, 0, 1);
    add(0, 7, 3, 7, 1, 0, 0, 0, 0, C_LU,   1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 2);
    add(0, 6, 8, 7, 1, 0, 0, 0, 0, C_NONE, 1, 0, 2);
    // Branch overrides load-use; branch alone.
    add(0, 1, 5, 5, 1, 1, 0, 0, 0, C_BR,   1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, C_BR,   1, 0, 2);
    // mc_cycles=4: 3 stall cycles, busy for 2.
    add(0, 0, 0, 0, 0, 0, 1, 4, 0, C_MC,   1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 5);
    // mc_cycles=2: one stall, never busy. mc_cycles=1 and 0: nothing.
    add(0, 0, 0, 0, 0, 0, 1, 2, 0, C_MC,   1, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 1, 0, 6);
    // mc_cycles=5 with branch/load-use ignored in MC and 2 cycles of ext_stall.
    add(0, 0, 0, 0, 0, 0, 1, 5, 0, C_MC,   1, 0, 6);
    add(0, 1, 5, 5, 1, 1, 0, 0, 0, C_MC,   1, 1, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, C_EXT,  1, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, C_EXT,  1, 1, 9);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1, 1, 10);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1, 1, 11);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 12);
    // ext_stall in IDLE outranks a taken branch.
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, C_EXT,  1, 0, 12);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 13);
    // Reset mid-MC (with competing inputs) aborts the sequence.
    add(0, 0, 0, 0, 0, 0, 1, 4, 0, C_MC,   1, 0, 13);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1, 1, 14);
    add(1, 1, 5, 5, 1, 1, 1, 6, 1, C_RST,  1, 1, 15);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Counter wrap: preload near the top, then stall across 0xFFFFFFFF -> 0.
    @(negedge clk);
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    w = '{rst: 0, rs1: 1, rs2: 5, rd: 5, mr: 1, br: 0, mcs: 0, mcc: 0, ext: 0,
          exp_ctl: C_LU, chk_state: 1, exp_busy: 0, exp_cnt: 32'hFFFF_FFFE};
    apply(w, "wrap_a");
    w.exp_cnt = 32'hFFFF_FFFF;
    apply(w, "wrap_b");
    w = '{rst: 0, rs1: 0, rs2: 0, rd: 0, mr: 0, br: 0, mcs: 0, mcc: 0, ext: 0,
          exp_ctl: C_NONE, chk_state: 1, exp_busy: 0, exp_cnt: 32'h0000_0000};
    apply(w, "wrap_c");
    apply(w, "wrap_d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
